ingress_rr_arbiter: RTL and testbench
=====================================

Name: ingress_rr_arbiter

Overview:
Upstream stage of the switch core. Collects frames from PORTS ingress ports and buffers one frame per port. A round-robin arbiter selects among the buffered frames and presents one frame per cycle on a single valid/ready stream into the switch core (memory write and MAC lookup path). The source and destination MAC fields are pre-extracted and tagged with the incoming port number, so the core needs no scan logic.

Parameters:
WIDTH, 128, frame word width in bits; must be >= 96.
PORTS, 16, number of ingress ports.
PORT_BITS, 4, width of port index; equals $clog2(PORTS).
CNT_WIDTH, 16, width of the drop counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  WIDTH x PORTS (unpacked [PORTS-1:0])  per-port frame word.
in_valid  input  PORTS  per-port frame strobe; one frame per asserted cycle.
out_data  output  WIDTH  selected frame.
out_port  output  PORT_BITS  index of the port the frame arrived on.
out_src_addr  output  48  out_data[47:0].
out_dst_addr  output  48  out_data[95:48].
out_broadcast  output  1  1 when out_dst_addr == 48'hFFFF_FFFF_FFFF.
out_valid  output  1  output frame valid.
out_ready  input  1  downstream accepts the frame when out_valid && out_ready.
hold_full  output  PORTS  per-port holding register occupied.
drop_pulse  output  1  1-cycle pulse, registered: at least one frame was dropped on the previous edge.
drop_count  output  CNT_WIDTH  total dropped frames; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high): all hold registers empty; out_valid=0; out_data, out_port, out_src_addr, out_dst_addr, out_broadcast = 0; drop_count=0; drop_pulse=0; rr pointer = PORTS-1 (port 0 has first priority). Reset mid-operation discards all held and output frames without emitting them.
- Per-port hold register: one entry plus an occupied flag, visible as hold_full[i].
  - Capture on an edge when in_valid[i] && (!hold_full[i] || port i granted this cycle).
  - A grant and a new capture on the same port in the same cycle are legal. The granted frame leaves and the new frame enters on one edge.
- Drop: in_valid[i] && hold_full[i] && port i not granted this cycle.
  - The incoming frame is discarded and the held frame is kept.
  - drop_count increments by the number of ports dropping that cycle, saturating at 2^CNT_WIDTH-1.
  - drop_pulse=1 on the following cycle.
- Output stage FSM:
  - OUT_EMPTY -> OUT_FULL when a grant occurs.
  - OUT_FULL -> OUT_FULL when out_ready is high and a new grant occurs (back-to-back, 1 frame per cycle).
  - OUT_FULL -> OUT_EMPTY when out_ready is high and no grant occurs.
  - OUT_FULL holds while out_ready is low. All output fields stay stable while out_valid && !out_ready.
- Grant enable: load_ok = !out_valid || out_ready. No grant is made when load_ok=0.
- Arbitration:
  - Candidates are ports with hold_full[i]=1 at the start of the cycle. Same-cycle in_valid is not a candidate.
  - Search starts at (rr_ptr+1) mod PORTS and wraps. The first occupied port wins.
  - On a grant, rr_ptr takes the winner's index. rr_ptr is unchanged when there is no grant.
- Latency: an uncontended frame captured at edge N appears with out_valid=1 after edge N+1 (2 cycles from in_valid to out_valid).
- Throughput: 1 frame/cycle aggregate. Any port continuously valid and continuously granted is never starved. Worst-case wait is PORTS-1 grants.
- Field extraction is registered together with out_data. out_broadcast is computed from the held frame before registering.

Test Plan:
- Single frame: reset, then port 3 in_valid=1 for one cycle with data_in[3][95:48]=48'h0000_1111_2222 and [47:0]=48'hAAAA_BBBB_CCCC, out_ready=1 -> two cycles later out_valid=1 for exactly one cycle with out_port=3, out_dst_addr=48'h0000_1111_2222, out_src_addr=48'hAAAA_BBBB_CCCC, out_broadcast=0; drop_count=0.
- Round-robin: ports 0, 5 and 15 each present one frame in the same cycle, out_ready=1 -> output order is port 0, then 5, then 15 on consecutive cycles. Next, ports 0 and 15 present together -> 0 is served first (pointer was 15, search wraps to 0).
- Backpressure: port 2 sends frame A, out_ready=0 for 5 cycles -> out_data=A stable and out_valid=1 throughout. Port 2 sends B (held) and then C -> C dropped, drop_pulse=1 once, drop_count=1. When out_ready=1, A then B are emitted.
- Same-cycle grant and capture: port 7 in_valid held high every cycle for 10 cycles with distinct words, out_ready=1 -> 10 frames emitted in order, back-to-back, drop_count=0.
- Broadcast and saturation: a frame with dst=48'hFFFF_FFFF_FFFF -> out_broadcast=1. With CNT_WIDTH=4, force 20 drops -> drop_count holds at 15.
- Reset mid-operation: with 4 ports held and out_valid=1, assert reset for one cycle -> next cycle out_valid=0, hold_full=0, drop_count=0. The first post-reset frames on ports 1 and 0 are served port 0 first.

Source files
------------

// File: rtl/ingress_rr_arbiter_if.sv
// Ingress arbiter bundle: per-port frame inputs plus the single core-facing output stream.
// The master modport is the environment side, and the slave modport is the arbiter side.
interface ingress_rr_arbiter_if #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned PORTS     = 16,
    parameter int unsigned PORT_BITS = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     data_in [PORTS-1:0];
    logic [PORTS-1:0]     in_valid;
    logic [WIDTH-1:0]     out_data;
    logic [PORT_BITS-1:0] out_port;
    logic [47:0]          out_src_addr;
    logic [47:0]          out_dst_addr;
    logic                 out_broadcast;
    logic                 out_valid;
    logic                 out_ready;
    logic [PORTS-1:0]     hold_full;
    logic                 drop_pulse;
    logic [CNT_WIDTH-1:0] drop_count;

    modport master (
        output data_in, in_valid, out_ready,
        input  out_data, out_port, out_src_addr, out_dst_addr, out_broadcast, out_valid,
        input  hold_full, drop_pulse, drop_count
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output out_data, out_port, out_src_addr, out_dst_addr, out_broadcast, out_valid,
        output hold_full, drop_pulse, drop_count
    );
endinterface

// File: rtl/ingress_rr_arbiter.sv
// Buffers one frame per ingress port and round-robin arbitrates them onto a single
// valid/ready stream, with MAC fields pre-extracted and a saturating drop counter.
module ingress_rr_arbiter #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned PORTS     = 16,
    parameter int unsigned PORT_BITS = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    ingress_rr_arbiter_if.slave bus
);
    typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

    out_state_e                 state_q, state_d;
    logic [WIDTH-1:0]           hold_q [PORTS-1:0];
    logic [PORTS-1:0]           hold_full_q, hold_full_d;
    logic [PORT_BITS-1:0]       rr_ptr_q;
    logic                       out_valid;
    logic                       load_ok;
    logic                       grant_valid;
    logic [PORT_BITS-1:0]       grant_idx;
    logic [PORTS-1:0]           grant_vec;
    logic [WIDTH-1:0]           grant_data;
    logic [PORTS-1:0]           capture;
    logic [PORTS-1:0]           drop;
    logic [PORT_BITS:0]         cand;
    logic [PORT_BITS:0]         drop_num;
    logic [CNT_WIDTH+PORT_BITS:0] cnt_sum;
    logic [CNT_WIDTH-1:0]       drop_count_q, drop_count_d;
    logic                       drop_pulse_q;
    logic [WIDTH-1:0]           out_data_q;
    logic [PORT_BITS-1:0]       out_port_q;
    logic                       out_broadcast_q;

    assign load_ok = !out_valid || bus.out_ready;

    // Search from rr_ptr+1 upward with wrap; only frames already held are candidates.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (load_ok) begin
            for (int i = 1; i <= int'(PORTS); i++) begin
                cand = {1'b0, rr_ptr_q} + (PORT_BITS+1)'(i);
                if (cand >= (PORT_BITS+1)'(PORTS)) begin
                    cand = cand - (PORT_BITS+1)'(PORTS);
                end
                if (!grant_valid && hold_full_q[cand[PORT_BITS-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[PORT_BITS-1:0];
                end
            end
        end
    end

    assign grant_data = hold_q[grant_idx];

    always_comb begin
        grant_vec = '0;
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        capture     = bus.in_valid & (~hold_full_q | grant_vec);
        drop        = bus.in_valid & hold_full_q & ~grant_vec;
        hold_full_d = capture | (hold_full_q & ~grant_vec);
    end

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            drop_num = drop_num + {{PORT_BITS{1'b0}}, drop[i]};
        end
        cnt_sum = {{(PORT_BITS+1){1'b0}}, drop_count_q} + {{CNT_WIDTH{1'b0}}, drop_num};
        if (cnt_sum > {{(PORT_BITS+1){1'b0}}, {CNT_WIDTH{1'b1}}}) begin
            drop_count_d = '1;
        end else begin
            drop_count_d = cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // Output stage FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (grant_valid) state_d = StFull;
            StFull: begin
                if (bus.out_ready) begin
                    state_d = grant_valid ? StFull : StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StFull);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_q     <= '0;
            rr_ptr_q        <= PORT_BITS'(PORTS - 1);
            drop_count_q    <= '0;
            drop_pulse_q    <= 1'b0;
            out_data_q      <= '0;
            out_port_q      <= '0;
            out_broadcast_q <= 1'b0;
        end else begin
            hold_full_q  <= hold_full_d;
            drop_count_q <= drop_count_d;
            drop_pulse_q <= |drop;
            if (grant_valid) begin
                rr_ptr_q        <= grant_idx;
                out_data_q      <= grant_data;
                out_port_q      <= grant_idx;
                out_broadcast_q <= &grant_data[95:48];
            end
        end
    end

    // Frame payload needs no reset; occupancy is tracked by hold_full_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(PORTS); i++) begin
            if (capture[i]) begin
                hold_q[i] <= bus.data_in[i];
            end
        end
    end

    assign bus.out_data      = out_data_q;
    assign bus.out_port      = out_port_q;
    assign bus.out_src_addr  = out_data_q[47:0];
    assign bus.out_dst_addr  = out_data_q[95:48];
    assign bus.out_broadcast = out_broadcast_q;
    assign bus.out_valid     = out_valid;
    assign bus.hold_full     = hold_full_q;
    assign bus.drop_pulse    = drop_pulse_q;
    assign bus.drop_count    = drop_count_q;
endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// Directed scoreboard bench for ingress_rr_arbiter: stimulus pushes expected frames,
// a negedge monitor pops and compares on every accepted output beat.
module tb_ingress_rr_arbiter;
    localparam int unsigned WIDTH     = 128;
    localparam int unsigned PORTS     = 16;
    localparam int unsigned PORT_BITS = 4;
    localparam int unsigned CNT_WIDTH = 4;

    typedef struct {
        int unsigned      port;
        logic [WIDTH-1:0] data;
        logic             bcast;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    ingress_rr_arbiter_if #(
        .WIDTH(WIDTH), .PORTS(PORTS), .PORT_BITS(PORT_BITS), .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    ingress_rr_arbiter #(
        .WIDTH(WIDTH), .PORTS(PORTS), .PORT_BITS(PORT_BITS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk(input logic [47:0] dst, input logic [47:0] src,
                                            input logic [31:0] tag);
        return {tag, dst, src};
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.in_valid = '0;
    endtask

    task automatic send(input int unsigned p, input logic [WIDTH-1:0] d);
        bus.data_in[p]  = d;
        bus.in_valid[p] = 1'b1;
    endtask

    task automatic push(input int unsigned p, input logic [WIDTH-1:0] d, input logic b);
        exp_t e;
        e.port  = p;
        e.data  = d;
        e.bcast = b;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL drain_timeout actual_left=%0d required_left=0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame actual_port=%0d required=none", bus.out_port);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_port", WIDTH'(bus.out_port), WIDTH'(e.port));
                chk("out_data", bus.out_data, e.data);
                chk("out_src_addr", WIDTH'(bus.out_src_addr), WIDTH'(e.data[47:0]));
                chk("out_dst_addr", WIDTH'(bus.out_dst_addr), WIDTH'(e.data[95:48]));
                chk("out_broadcast", WIDTH'(bus.out_broadcast), WIDTH'(e.bcast));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] fa, fb, fc, fx, fy, fz;
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < int'(PORTS); i++) bus.data_in[i] = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", WIDTH'(bus.out_valid), 0);
        chk("rst_hold_full", WIDTH'(bus.hold_full), 0);
        chk("rst_drop_count", WIDTH'(bus.drop_count), 0);
        chk("rst_drop_pulse", WIDTH'(bus.drop_pulse), 0);
        chk("rst_out_data", bus.out_data, 0);

        // Single frame on port 3
        fa = mk(48'h0000_1111_2222, 48'hAAAA_BBBB_CCCC, 32'h1);
        send(3, fa);
        push(3, fa, 1'b0);
        tick();
        clr();
        chk("single_hold", WIDTH'(bus.hold_full), WIDTH'(16'h0008));
        chk("single_valid_early", WIDTH'(bus.out_valid), 0);
        tick();
        chk("single_valid", WIDTH'(bus.out_valid), 1);
        tick();
        chk("single_one_cycle", WIDTH'(bus.out_valid), 0);
        chk("single_drops", WIDTH'(bus.drop_count), 0);
        wait_drain();

        // Round robin: 0,5,15 then 0,15 with pointer at 15
        do_reset();
        send(0, mk(48'h10, 48'h20, 32'h100));
        send(5, mk(48'h15, 48'h25, 32'h105));
        send(15, mk(48'h1F, 48'h2F, 32'h10F));
        push(0, mk(48'h10, 48'h20, 32'h100), 1'b0);
        push(5, mk(48'h15, 48'h25, 32'h105), 1'b0);
        push(15, mk(48'h1F, 48'h2F, 32'h10F), 1'b0);
        tick();
        clr();
        tick();
        chk("rr_first_port", WIDTH'(bus.out_port), 0);
        wait_drain();
        send(0, mk(48'h30, 48'h40, 32'h200));
        send(15, mk(48'h3F, 48'h4F, 32'h20F));
        push(0, mk(48'h30, 48'h40, 32'h200), 1'b0);
        push(15, mk(48'h3F, 48'h4F, 32'h20F), 1'b0);
        tick();
        clr();
        wait_drain();

        // Backpressure with hold and drop on port 2
        do_reset();
        fa = mk(48'hA1, 48'hA2, 32'hA);
        fb = mk(48'hB1, 48'hB2, 32'hB);
        fc = mk(48'hC1, 48'hC2, 32'hC);
        bus.out_ready = 1'b0;
        send(2, fa);
        tick();
        clr();
        tick();
        chk("bp_valid0", WIDTH'(bus.out_valid), 1);
        chk("bp_data0", bus.out_data, fa);
        send(2, fb);
        tick();
        clr();
        chk("bp_data1", bus.out_data, fa);
        chk("bp_hold_b", WIDTH'(bus.hold_full), WIDTH'(16'h0004));
        send(2, fc);
        tick();
        clr();
        chk("bp_data2", bus.out_data, fa);
        chk("bp_drop_pulse", WIDTH'(bus.drop_pulse), 1);
        chk("bp_drop_count", WIDTH'(bus.drop_count), 1);
        tick();
        chk("bp_data3", bus.out_data, fa);
        chk("bp_drop_pulse_once", WIDTH'(bus.drop_pulse), 0);
        tick();
        chk("bp_valid4", WIDTH'(bus.out_valid), 1);
        chk("bp_data4", bus.out_data, fa);
        push(2, fa, 1'b0);
        push(2, fb, 1'b0);
        bus.out_ready = 1'b1;
        wait_drain();
        chk("bp_drop_final", WIDTH'(bus.drop_count), 1);

        // Same-cycle grant and capture on port 7
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send(7, mk(48'h7000 + 48'(k), 48'h7777, 32'(k)));
            push(7, mk(48'h7000 + 48'(k), 48'h7777, 32'(k)), 1'b0);
            tick();
            if (k >= 1) chk("b2b_valid", WIDTH'(bus.out_valid), 1);
        end
        clr();
        tick();
        chk("b2b_last_valid", WIDTH'(bus.out_valid), 1);
        wait_drain();
        chk("b2b_drops", WIDTH'(bus.drop_count), 0);

        // Broadcast then drop-count saturation
        do_reset();
        send(4, mk(48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 32'hBC));
        push(4, mk(48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 32'hBC), 1'b1);
        tick();
        clr();
        wait_drain();
        fx = mk(48'hFFFF_FFFF_FFFE, 48'h11, 32'hE1);
        fy = mk(48'h22, 48'h23, 32'hE2);
        fz = mk(48'h33, 48'h34, 32'hE3);
        bus.out_ready = 1'b0;
        send(1, fx);
        tick();
        clr();
        tick();
        send(1, fy);
        send(2, fz);
        tick();
        clr();
        chk("sat_hold", WIDTH'(bus.hold_full), WIDTH'(16'h0006));
        for (int k = 0; k < 10; k++) begin
            send(1, mk(48'hDEAD, 48'(k), 32'hD1));
            send(2, mk(48'hBEEF, 48'(k), 32'hD2));
            tick();
            if (k == 2) chk("sat_multi_drop", WIDTH'(bus.drop_count), 6);
        end
        clr();
        chk("sat_count", WIDTH'(bus.drop_count), 15);
        push(1, fx, 1'b0);
        push(2, fz, 1'b0);
        push(1, fy, 1'b0);
        bus.out_ready = 1'b1;
        wait_drain();
        chk("sat_hold_at_max", WIDTH'(bus.drop_count), 15);

        // Reset mid-operation with four ports held
        bus.out_ready = 1'b0;
        send(3, mk(48'h3, 48'h3, 32'h3));
        send(6, mk(48'h6, 48'h6, 32'h6));
        send(9, mk(48'h9, 48'h9, 32'h9));
        send(12, mk(48'hC, 48'hC, 32'hC));
        tick();
        clr();
        tick();
        send(3, mk(48'h33, 48'h33, 32'h33));
        tick();
        clr();
        chk("mid_hold", WIDTH'(bus.hold_full), WIDTH'(16'h1248));
        chk("mid_valid", WIDTH'(bus.out_valid), 1);
        chk("mid_out_port", WIDTH'(bus.out_port), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", WIDTH'(bus.out_valid), 0);
        chk("mid_rst_hold", WIDTH'(bus.hold_full), 0);
        chk("mid_rst_drops", WIDTH'(bus.drop_count), 0);
        chk("mid_rst_data", bus.out_data, 0);
        bus.out_ready = 1'b1;
        send(1, mk(48'h51, 48'h61, 32'h71));
        send(0, mk(48'h50, 48'h60, 32'h70));
        push(0, mk(48'h50, 48'h60, 32'h70), 1'b0);
        push(1, mk(48'h51, 48'h61, 32'h71), 1'b0);
        tick();
        clr();
        wait_drain();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
